// File: rtl/reset_gen_pkg.sv
// Shared types and board-clock defaults for the reset generator.
// Cycle constants assume the 24 MHz board clock.
package reset_gen_pkg;

    typedef enum logic [1:0] {
        S_POR    = 2'd0,
        S_RUN    = 2'd1,
        S_ASSERT = 2'd2
    } state_e;

    localparam int DEF_POR_CYCLES      = 2400;
    localparam int DEF_DEBOUNCE_CYCLES = 240000;
    localparam int DEF_PULSE_CYCLES    = 240;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_gen_if.sv
// Button input and reset-request outputs of reset_gen.
// The slave side is the reset generator; the master side is the board or bench.
interface reset_gen_if;

    logic i_btn_n;
    logic o_res_n;
    logic o_btn_level;

    modport master (
        output i_btn_n,
        input  o_res_n,
        input  o_btn_level
    );

    modport slave (
        input  i_btn_n,
        output o_res_n,
        output o_btn_level
    );

endinterface

// File: rtl/reset_gen_btn_debounce.sv
// Two-flop synchroniser plus persistence debouncer for the active-low push-button.
// A new level is accepted only after it has been seen for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic i_clk,
    input  logic i_res,
    input  logic i_btn_n,
    output logic o_btn_level
);

    localparam int DC_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 1");
    end

    logic            ff1_q, ff2_q;
    logic            level_q, level_d;
    logic [DC_W-1:0] dc_q, dc_d;
    logic            s;

    assign s = ~ff2_q;

    always_comb begin
        level_d = level_q;
        dc_d    = dc_q;
        if (s == level_q) begin
            dc_d = '0;
        end else if (dc_q == DC_LAST) begin
            level_d = s;
            dc_d    = '0;
        end else begin
            dc_d = dc_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            ff1_q   <= 1'b1;
            ff2_q   <= 1'b1;
            level_q <= 1'b0;
            dc_q    <= '0;
        end else begin
            ff1_q   <= i_btn_n;
            ff2_q   <= ff1_q;
            level_q <= level_d;
            dc_q    <= dc_d;
        end
    end

    assign o_btn_level = level_q;

endmodule

// File: rtl/reset_gen.sv
// Power-on and push-button reset request generator.
// Holds reset for POR_CYCLES, then issues a minimum-width pulse per debounced press.
module reset_gen
    import reset_gen_pkg::*;
#(
    parameter int POR_CYCLES      = DEF_POR_CYCLES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES
) (
    input logic        i_clk,
    input logic        i_res,
    reset_gen_if.slave bus
);

    localparam int PC_MAX = max_int(POR_CYCLES, PULSE_CYCLES);
    localparam int PC_W   = (PC_MAX > 1) ? $clog2(PC_MAX) : 1;
    localparam logic [PC_W-1:0] POR_LAST   = PC_W'(POR_CYCLES - 1);
    localparam logic [PC_W-1:0] PULSE_LAST = PC_W'(PULSE_CYCLES - 1);

    if (POR_CYCLES < 1) begin : g_bad_por
        $error("POR_CYCLES must be >= 1");
    end
    if (PULSE_CYCLES < 1) begin : g_bad_pulse
        $error("PULSE_CYCLES must be >= 1");
    end

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            res_n_q, res_n_d;
    logic            level;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .i_clk      (i_clk),
        .i_res      (i_res),
        .i_btn_n    (bus.i_btn_n),
        .o_btn_level(level)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        res_n_d = res_n_q;
        unique case (state_q)
            S_POR: begin
                res_n_d = 1'b0;
                if (pc_q == POR_LAST) begin
                    pc_d = '0;
                    if (level) begin
                        state_d = S_ASSERT;
                    end else begin
                        state_d = S_RUN;
                        res_n_d = 1'b1;
                    end
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            S_RUN: begin
                res_n_d = 1'b1;
                if (level) begin
                    res_n_d = 1'b0;
                    pc_d    = '0;
                    state_d = S_ASSERT;
                end
            end
            S_ASSERT: begin
                res_n_d = 1'b0;
                // Counter saturates; the pulse ends only once the button is also released.
                if (pc_q != PULSE_LAST) begin
                    pc_d = pc_q + 1'b1;
                end else if (!level) begin
                    res_n_d = 1'b1;
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_POR;
                pc_d    = '0;
                res_n_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            state_q <= S_POR;
            pc_q    <= '0;
            res_n_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            res_n_q <= res_n_d;
        end
    end

    assign bus.o_res_n     = res_n_q;
    assign bus.o_btn_level = level;

endmodule

// File: tb/tb_reset_gen.sv
// Bench for reset_gen: two instances (short and long pulse) share one button stimulus
// and are checked every cycle against a timing model plus directed literal expectations.
module tb_reset_gen;

    localparam int POR = 16;
    localparam int DEB = 8;
    localparam int NMAX = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b1;

    int checks = 0;
    int errors = 0;

    reset_gen_if bif ();
    reset_gen_if bif32 ();

    assign bif.i_btn_n   = btn;
    assign bif32.i_btn_n = btn;

    reset_gen #(
        .POR_CYCLES(POR), .DEBOUNCE_CYCLES(DEB), .PULSE_CYCLES(4)
    ) dut (
        .i_clk(clk), .i_res(rst), .bus(bif)
    );

    reset_gen #(
        .POR_CYCLES(POR), .DEBOUNCE_CYCLES(DEB), .PULSE_CYCLES(32)
    ) dut32 (
        .i_clk(clk), .i_res(rst), .bus(bif32)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: edge count since reset release, debounced level and per-instance reset output.
    int mn = 0;
    bit m_l = 1'b0;
    bit m_res [2];
    int m_start [2];
    int m_pulse [2] = '{4, 32};
    bit raw_a [NMAX];
    bit s_a [NMAX];

    always @(posedge clk) begin
        bit b, r, l_prev, flip, res_prev;
        b = btn;
        r = rst;
        #1;
        if (r) begin
            mn = 0;
            m_l = 1'b0;
            m_res[0] = 1'b0;
            m_res[1] = 1'b0;
            s_a[0] = 1'b0;
        end else if (mn < NMAX - 1) begin
            mn++;
            raw_a[mn] = b;
            l_prev = m_l;
            // Level flips once the synchronised sample disagreed for DEB straight cycles.
            flip = 1'b0;
            if (mn >= DEB) begin
                flip = 1'b1;
                for (int j = 1; j <= DEB; j++)
                    if (s_a[mn - j] == l_prev) flip = 1'b0;
            end
            if (flip) m_l = ~l_prev;
            s_a[mn] = (mn >= 2) ? ~raw_a[mn - 1] : 1'b0;
            for (int i = 0; i < 2; i++) begin
                res_prev = m_res[i];
                if (mn < POR) begin
                    m_res[i] = 1'b0;
                end else if (mn == POR) begin
                    m_res[i] = ~l_prev;
                    m_start[i] = mn;
                end else if (res_prev) begin
                    if (l_prev) begin
                        m_res[i] = 1'b0;
                        m_start[i] = mn;
                    end
                end else if ((mn - m_start[i] >= m_pulse[i]) && !l_prev) begin
                    m_res[i] = 1'b1;
                end
            end
        end
        check("res_n", bif.o_res_n, m_res[0]);
        check("res_n32", bif32.o_res_n, m_res[1]);
        check("btn_level", bif.o_btn_level, m_l);
        check("btn_level32", bif32.o_btn_level, m_l);
    end

    // Returns at the falling edge following rising edge e (counted from reset release).
    task automatic at_edge(input int e);
        int guard;
        guard = 0;
        while (mn < e && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (mn < e) begin
            checks++;
            errors++;
            $display("FAIL at_edge timeout: reached %0d, wanted %0d", mn, e);
        end
    endtask

    task automatic reset_pulse(input logic btn_during);
        @(negedge clk);
        rst = 1'b1;
        btn = btn_during;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_por();
        at_edge(15);
        check("por_low_e15", bif.o_res_n, 1'b0);
        check("por_lvl_e15", bif.o_btn_level, 1'b0);
        at_edge(16);
        check("por_high_e16", bif.o_res_n, 1'b1);
        check("por32_high_e16", bif32.o_res_n, 1'b1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_res_n", bif.o_res_n, 1'b0);
        check("rst_level", bif.o_btn_level, 1'b0);
        rst = 1'b0;

        // Power-on with idle button.
        check_por();

        // 30-cycle press.
        at_edge(30); btn = 1'b0;
        at_edge(39); check("press_lvl_e39", bif.o_btn_level, 1'b0);
        at_edge(40); check("press_lvl_e40", bif.o_btn_level, 1'b1);
        check("press_res_e40", bif.o_res_n, 1'b1);
        at_edge(41); check("press_res_e41", bif.o_res_n, 1'b0);
        at_edge(60); btn = 1'b1;
        at_edge(69); check("rel_lvl_e69", bif.o_btn_level, 1'b1);
        at_edge(70); check("rel_lvl_e70", bif.o_btn_level, 1'b0);
        check("rel_res_e70", bif.o_res_n, 1'b0);
        at_edge(71); check("rel_res_e71", bif.o_res_n, 1'b1);
        at_edge(72); check("rel32_res_e72", bif32.o_res_n, 1'b0);
        at_edge(73); check("rel32_res_e73", bif32.o_res_n, 1'b1);

        // Bounce train: 5 low, 3 high, for 60 cycles.
        at_edge(80);
        for (int k = 0; k < 60; k++) begin
            btn = ((k % 8) < 5) ? 1'b0 : 1'b1;
            @(negedge clk);
            check("bounce_lvl", bif.o_btn_level, 1'b0);
            check("bounce_res", bif.o_res_n, 1'b1);
        end
        btn = 1'b1;
        at_edge(160);
        check("bounce_end_lvl", bif.o_btn_level, 1'b0);
        check("bounce_end_res", bif.o_res_n, 1'b1);

        // 12-cycle press: long-pulse instance outlasts the debounced release.
        btn = 1'b0;
        at_edge(170); check("short_lvl_e170", bif.o_btn_level, 1'b1);
        at_edge(171); check("short_res_e171", bif.o_res_n, 1'b0);
        check("short32_res_e171", bif32.o_res_n, 1'b0);
        at_edge(172); btn = 1'b1;
        at_edge(182); check("short_lvl_e182", bif.o_btn_level, 1'b0);
        check("short_res_e182", bif.o_res_n, 1'b0);
        at_edge(183); check("short_res_e183", bif.o_res_n, 1'b1);
        at_edge(202); check("short32_res_e202", bif32.o_res_n, 1'b0);
        at_edge(203); check("short32_res_e203", bif32.o_res_n, 1'b1);

        // Button held through reset release until edge 40.
        at_edge(210);
        reset_pulse(1'b0);
        for (int e = 1; e <= 50; e++) begin
            at_edge(e);
            if (e == 40) btn = 1'b1;
            check("held_res_low", bif.o_res_n, 1'b0);
            check("held32_res_low", bif32.o_res_n, 1'b0);
        end
        check("held_lvl_e50", bif.o_btn_level, 1'b0);
        at_edge(51);
        check("held_res_e51", bif.o_res_n, 1'b1);
        check("held32_res_e51", bif32.o_res_n, 1'b1);

        // Asynchronous reset in the middle of S_ASSERT.
        at_edge(60); btn = 1'b0;
        at_edge(73);
        check("pre_async_lvl", bif.o_btn_level, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_assert_res", bif.o_res_n, 1'b0);
        check("async_assert_lvl", bif.o_btn_level, 1'b0);
        @(negedge clk); btn = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_por();

        // Asynchronous reset in the middle of S_RUN.
        at_edge(30);
        check("pre_async_run_res", bif.o_res_n, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_run_res", bif.o_res_n, 1'b0);
        check("async_run_lvl", bif.o_btn_level, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_por();
        at_edge(25);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reset_gen.md
# reset_gen

Power-on and push-button reset source for the pattern generator. Holds a reset request for a fixed power-on interval, then monitors the board's active-low push-button through a synchroniser and debouncer. It drives a clean, minimum-width, active-low reset request into the design's downstream reset synchroniser, which provides async-assert / sync-deassert distribution. All timing is counted in `i_clk` cycles, 24 MHz on the board.

## Interface
- `POR_CYCLES`, default 2400: power-on hold after `i_res` release (100 µs); must be ≥1.
- `DEBOUNCE_CYCLES`, default 240000: cycles a new button level must persist before acceptance (10 ms); must be ≥1.
- `PULSE_CYCLES`, default 240: minimum low width of a button-initiated `o_res_n` pulse; must be ≥1.
- `i_clk`  in  1  single system clock; the only clock in the block.
- `i_res`  in  1  reset, asynchronous, active-high.
- `i_btn_n`  in  1  raw push-button, active-low; asynchronous to `i_clk` and may bounce.
- `o_res_n`  out  1  registered reset request, active-low; feeds the downstream synchroniser.
- `o_btn_level`  out  1  debounced button level; 1 means pressed.

## Operation
- Input synchroniser:
  - 2 FFs on `i_btn_n`, both reset to 1 (not pressed).
  - Synchronised sample `s = ~ff2`.
- Debouncer:
  - Stable level `L` drives `o_btn_level`.
  - Counter `dc` has width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If `s == L`: `dc <= 0`.
  - Otherwise, if `dc == DEBOUNCE_CYCLES-1`: `L <= s` and `dc <= 0`; else `dc <= dc+1`.
  - Any glitch shorter than `DEBOUNCE_CYCLES` cycles is discarded, because the counter restarts.
- FSM states: `S_POR`, `S_RUN`, `S_ASSERT`. A shared counter `pc` is sized for `max(POR_CYCLES, PULSE_CYCLES)`.
- `S_POR`:
  - `o_res_n = 0`; `pc` counts up from 0.
  - When `pc == POR_CYCLES-1`: `pc <= 0`. Go to `S_ASSERT` if `L == 1` (`o_res_n` stays 0); otherwise go to `S_RUN` with `o_res_n <= 1`.
- `S_RUN`:
  - `o_res_n = 1`.
  - When `L == 1`: `o_res_n <= 0`, `pc <= 0`, go to `S_ASSERT`.
- `S_ASSERT`:
  - `o_res_n = 0`; `pc` increments and saturates at `PULSE_CYCLES-1`.
  - Exit when `pc == PULSE_CYCLES-1` and `L == 0`: `o_res_n <= 1`, go to `S_RUN`.
  - The pulse width is therefore `max(PULSE_CYCLES, time until debounced release)`.
- Reset values:
  - Synchroniser FFs = 1; `L` = 0; `dc` = 0; `pc` = 0.
  - State = `S_POR`; `o_res_n` = 0; `o_btn_level` = 0.
- `i_res` asserted in any state:
  - `o_res_n` drops to 0 and `o_btn_level` to 0 immediately, without waiting for a clock edge.
  - The full power-on sequence restarts after release.
- A debounced press during `S_POR` does not shorten or extend the POR interval. It only selects `S_ASSERT` at POR end.

## Timing
- Edge 1 is defined as the first rising edge of `i_clk` after `i_res` falls.
- Power-on: `o_res_n` is 0 through edge `POR_CYCLES-1` and is 1 after edge `POR_CYCLES`.
- Button latency is measured from the edge that first samples the new `i_btn_n` value:
  - `ff2` updates at +2.
  - `o_btn_level` updates at +`DEBOUNCE_CYCLES`+2.
  - `o_res_n` updates one edge later, at +`DEBOUNCE_CYCLES`+3, for both press and release.
- `o_res_n` is driven directly from a flop, with no combinational path from any input. The asynchronous `i_res` clear is the sole exception.
- Throughput: one new reset pulse at most per debounced press/release pair. Re-pressing while in `S_ASSERT` does not queue a second pulse.

## Structure
- Package `reset_gen_pkg` holds:
  - state encodings `S_POR`, `S_RUN`, `S_ASSERT` (2 bits);
  - default cycle constants for the 24 MHz board clock.
- Sub-module `btn_debounce` holds the synchroniser, the debouncer, `DEBOUNCE_CYCLES` and the `o_btn_level` output. The FSM and `pc` stay in `reset_gen`.
- Parameter elaboration checks: any parameter < 1 is an elaboration error.

## Test plan
Bench parameters: `POR_CYCLES`=16, `DEBOUNCE_CYCLES`=8, `PULSE_CYCLES`=4 unless stated.
- Release `i_res` with the button idle → `o_res_n` is 0 through edge 15 and 1 after edge 16; `o_btn_level` stays 0 throughout.
- Press `i_btn_n` low for 30 cycles after POR, then release:
  - `o_btn_level` rises at +10 and `o_res_n` falls at +11.
  - On release, `o_btn_level` falls at +10 and `o_res_n` rises at +11.
- Bounce train of 5-cycle lows and 3-cycle highs for 60 cycles, then held high → `o_btn_level` and `o_res_n` never change.
- With `PULSE_CYCLES`=32, a 12-cycle press → `o_res_n` stays low for exactly 32 cycles, outlasting the debounced release.
- Button held low from before `i_res` release until edge 40 → `o_res_n` stays continuously 0 and rises 11 edges after release is sampled.
- Assert `i_res` mid-`S_ASSERT` and mid-`S_RUN`:
  - `o_res_n` = 0 and `o_btn_level` = 0 within the same cycle, without a clock edge.
  - After release, the 16-cycle POR repeats exactly.
